// File: rtl/sdf_bf2_stage.sv
// Radix-2 single-path delay-feedback butterfly stage, 16 lanes wide.
// Drives and consumes an external free-running delay buffer of DEPTH/16 cycles.
module sdf_bf2_stage #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned WIDTH = 10
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    din_valid,
    input  logic signed [WIDTH-1:0] di_re    [0:15],
    input  logic signed [WIDTH-1:0] di_im    [0:15],
    output logic signed [WIDTH:0]   db_di_re [0:15],
    output logic signed [WIDTH:0]   db_di_im [0:15],
    input  logic signed [WIDTH:0]   db_do_re [0:15],
    input  logic signed [WIDTH:0]   db_do_im [0:15],
    output logic                    do_valid,
    output logic signed [WIDTH:0]   do_re    [0:15],
    output logic signed [WIDTH:0]   do_im    [0:15],
    output logic                    err
);

    localparam int unsigned D  = DEPTH / 16;
    localparam int unsigned CW = (D > 1) ? $clog2(D) : 1;
    localparam logic [CW-1:0] CntLast = CW'(D - 1);

    typedef enum logic [1:0] {StIdle, StFill, StBfly, StDrain} state_e;

    state_e                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   pending_q, pending_d;
    logic                   err_q, err_d;
    logic                   do_valid_q, do_valid_d;
    logic signed [WIDTH:0]  do_re_q [0:15];
    logic signed [WIDTH:0]  do_im_q [0:15];
    logic signed [WIDTH:0]  do_re_d [0:15];
    logic signed [WIDTH:0]  do_im_d [0:15];
    logic signed [WIDTH:0]  di_ext_re [0:15];
    logic signed [WIDTH:0]  di_ext_im [0:15];
    logic                   cnt_last;

    assign cnt_last = (cnt_q == CntLast);

    // Control: din_valid only steers the FSM on frame boundaries; elsewhere it is a
    // protocol check.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pending_d = pending_q;
        err_d     = err_q;
        unique case (state_q)
            StIdle: begin
                if (din_valid) begin
                    state_d = StFill;
                    cnt_d   = '0;
                end
            end
            StFill: begin
                if (!din_valid) err_d = 1'b1;
                if (cnt_last) begin
                    state_d = StBfly;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StBfly: begin
                if (cnt_last) begin
                    pending_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = din_valid ? StFill : StDrain;
                end else begin
                    if (!din_valid) err_d = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDrain: begin
                if (cnt_last) begin
                    pending_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = din_valid ? StFill : StIdle;
                end else begin
                    if (din_valid) err_d = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        for (int k = 0; k < 16; k++) begin
            di_ext_re[k] = {di_re[k][WIDTH-1], di_re[k]};
            di_ext_im[k] = {di_im[k][WIDTH-1], di_im[k]};
        end
    end

    // Datapath: FILL stores x[n], BFLY emits the sum and stores the difference,
    // DRAIN flushes the stored differences once input has stopped.
    always_comb begin
        do_valid_d = 1'b0;
        for (int k = 0; k < 16; k++) begin
            db_di_re[k] = '0;
            db_di_im[k] = '0;
            do_re_d[k]  = do_re_q[k];
            do_im_d[k]  = do_im_q[k];
            unique case (state_q)
                StFill: begin
                    db_di_re[k] = di_ext_re[k];
                    db_di_im[k] = di_ext_im[k];
                    do_re_d[k]  = db_do_re[k];
                    do_im_d[k]  = db_do_im[k];
                end
                StBfly: begin
                    db_di_re[k] = db_do_re[k] - di_ext_re[k];
                    db_di_im[k] = db_do_im[k] - di_ext_im[k];
                    do_re_d[k]  = db_do_re[k] + di_ext_re[k];
                    do_im_d[k]  = db_do_im[k] + di_ext_im[k];
                end
                StDrain: begin
                    do_re_d[k] = db_do_re[k];
                    do_im_d[k] = db_do_im[k];
                end
                default: ;
            endcase
        end
        unique case (state_q)
            StFill:  do_valid_d = pending_q;
            StBfly:  do_valid_d = 1'b1;
            StDrain: do_valid_d = 1'b1;
            default: do_valid_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            pending_q  <= 1'b0;
            err_q      <= 1'b0;
            do_valid_q <= 1'b0;
            do_re_q    <= '{default: '0};
            do_im_q    <= '{default: '0};
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pending_q  <= pending_d;
            err_q      <= err_d;
            do_valid_q <= do_valid_d;
            do_re_q    <= do_re_d;
            do_im_q    <= do_im_d;
        end
    end

    assign do_valid = do_valid_q;
    assign do_re    = do_re_q;
    assign do_im    = do_im_q;
    assign err      = err_q;

endmodule

// File: tb/tb_sdf_bf2_stage.sv
// Self-checking bench for sdf_bf2_stage: models the delay buffer and predicts the
// output stream frame by frame (D sums, then D differences).
module tb_sdf_bf2_stage;

    localparam int DEPTH = 256;
    localparam int WIDTH = 10;
    localparam int D     = DEPTH / 16;
    localparam int OW    = WIDTH + 1;
    localparam int L     = 16;

    typedef logic [L*WIDTH-1:0] ivec_t;
    typedef logic [L*OW-1:0]    ovec_t;
    typedef struct packed {
        logic [31:0] cyc;
        ovec_t       re;
        ovec_t       im;
    } samp_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic din_valid = 1'b0;
    logic signed [WIDTH-1:0] di_re [0:15];
    logic signed [WIDTH-1:0] di_im [0:15];
    logic signed [OW-1:0] db_di_re [0:15];
    logic signed [OW-1:0] db_di_im [0:15];
    logic signed [OW-1:0] db_do_re [0:15];
    logic signed [OW-1:0] db_do_im [0:15];
    logic signed [OW-1:0] do_re [0:15];
    logic signed [OW-1:0] do_im [0:15];
    logic do_valid;
    logic err;

    ivec_t cur_re = '0;
    ivec_t cur_im = '0;
    ovec_t dbi_re, dbi_im, out_re, out_im;
    ovec_t dbuf_re [D];
    ovec_t dbuf_im [D];

    int cyc = 0;
    int n_checks = 0;
    int n_errors = 0;

    samp_t obs_q[$];
    samp_t exp_q[$];
    ivec_t s_re[$];
    ivec_t s_im[$];
    bit    s_f[$];
    bit    s_v[$];
    int    frames[$];

    sdf_bf2_stage #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .din_valid(din_valid),
        .di_re    (di_re),
        .di_im    (di_im),
        .db_di_re (db_di_re),
        .db_di_im (db_di_im),
        .db_do_re (db_do_re),
        .db_do_im (db_do_im),
        .do_valid (do_valid),
        .do_re    (do_re),
        .do_im    (do_im),
        .err      (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Free-running external delay buffer, D cycles deep.
    always @(posedge clk) begin
        for (int i = D - 1; i > 0; i--) begin
            dbuf_re[i] <= dbuf_re[i-1];
            dbuf_im[i] <= dbuf_im[i-1];
        end
        dbuf_re[0] <= dbi_re;
        dbuf_im[0] <= dbi_im;
    end

    always_comb begin
        for (int k = 0; k < L; k++) begin
            di_re[k]    = cur_re[k*WIDTH +: WIDTH];
            di_im[k]    = cur_im[k*WIDTH +: WIDTH];
            db_do_re[k] = dbuf_re[D-1][k*OW +: OW];
            db_do_im[k] = dbuf_im[D-1][k*OW +: OW];
        end
    end

    always_comb begin
        dbi_re = '0;
        dbi_im = '0;
        out_re = '0;
        out_im = '0;
        for (int k = 0; k < L; k++) begin
            dbi_re[k*OW +: OW] = db_di_re[k];
            dbi_im[k*OW +: OW] = db_di_im[k];
            out_re[k*OW +: OW] = do_re[k];
            out_im[k*OW +: OW] = do_im[k];
        end
    end

    always @(negedge clk) begin
        if (rstn && do_valid) obs_q.push_back(samp_t'{32'(cyc), out_re, out_im});
    end

    function automatic int ilane(input ivec_t v, input int k);
        return int'($signed(v[k*WIDTH +: WIDTH]));
    endfunction

    function automatic int olane(input ovec_t v, input int k);
        return int'($signed(v[k*OW +: OW]));
    endfunction

    function automatic ivec_t const_vec(input int val);
        ivec_t r;
        for (int k = 0; k < L; k++) r[k*WIDTH +: WIDTH] = WIDTH'(val);
        return r;
    endfunction

    function automatic ivec_t rand_vec();
        ivec_t r;
        for (int k = 0; k < L; k++) r[k*WIDTH +: WIDTH] = WIDTH'($urandom);
        return r;
    endfunction

    task automatic clear_stim();
        s_re.delete();
        s_im.delete();
        s_f.delete();
        s_v.delete();
        frames.delete();
    endtask

    task automatic push_cycle(input bit f, input ivec_t re, input ivec_t im);
        s_f.push_back(f);
        s_re.push_back(re);
        s_im.push_back(im);
    endtask

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) push_cycle(1'b0, rand_vec(), rand_vec());
    endtask

    task automatic push_rand_frame();
        frames.push_back(s_f.size());
        for (int n = 0; n < 2 * D; n++) push_cycle(1'b1, rand_vec(), rand_vec());
    endtask

    // din_valid announces one cycle ahead that the next cycle belongs to a frame.
    task automatic finalize_valid();
        s_v.delete();
        for (int i = 0; i < s_f.size(); i++)
            s_v.push_back((i + 1 < s_f.size()) ? s_f[i+1] : 1'b0);
    endtask

    // Drives the stimulus and predicts: sum of pair n one cycle after x[n+D] is
    // presented, the matching difference D cycles after that.
    task automatic play();
        int t0, fs, ar, br, ai, bi;
        ovec_t ere, eim;
        t0 = cyc;
        obs_q.delete();
        exp_q.delete();
        for (int i = 0; i < s_f.size(); i++) begin
            din_valid = s_v[i];
            cur_re    = s_re[i];
            cur_im    = s_im[i];
            @(posedge clk);
            #1;
        end
        din_valid = 1'b0;
        foreach (frames[f]) begin
            fs = frames[f];
            for (int h = 0; h < 2; h++) begin
                for (int n = 0; n < D; n++) begin
                    for (int k = 0; k < L; k++) begin
                        ar = ilane(s_re[fs+n], k);
                        br = ilane(s_re[fs+n+D], k);
                        ai = ilane(s_im[fs+n], k);
                        bi = ilane(s_im[fs+n+D], k);
                        ere[k*OW +: OW] = OW'((h == 0) ? ar + br : ar - br);
                        eim[k*OW +: OW] = OW'((h == 0) ? ai + bi : ai - bi);
                    end
                    exp_q.push_back(samp_t'{32'(t0 + fs + n + D * (h + 1) + 1), ere, eim});
                end
            end
        end
    endtask

    task automatic pulse_reset();
        rstn = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (do_valid !== 1'b0 || err !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_flags: do_valid=%b err=%b, expected 0 0", do_valid, err);
        end
        n_checks++;
        if (out_re !== '0 || out_im !== '0) begin
            n_errors++;
            $display("FAIL reset_data: re=%h im=%h, expected all zero", out_re, out_im);
        end
        rstn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_ramp();
        ivec_t r;
        bit ok;
        clear_stim();
        push_idle(1);
        frames.push_back(1);
        for (int n = 0; n < 2 * D; n++) begin
            for (int k = 0; k < L; k++) r[k*WIDTH +: WIDTH] = WIDTH'(n + k);
            push_cycle(1'b1, r, '0);
        end
        push_idle(2 * D + 2);
        finalize_valid();
        play();
        n_checks++;
        if (obs_q.size() !== exp_q.size()) begin
            n_errors++;
            $display("FAIL ramp_count: got %0d outputs, expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_errors++;
                $display("FAIL ramp_out[%0d]: got cyc=%0d re=%h im=%h, expected cyc=%0d re=%h im=%h",
                         i, obs_q[i].cyc, obs_q[i].re, obs_q[i].im,
                         exp_q[i].cyc, exp_q[i].re, exp_q[i].im);
            end
        end
        if (obs_q.size() >= 2 * D) begin
            ok = 1'b1;
            for (int j = 0; j < D; j++)
                for (int k = 0; k < L; k++)
                    if (olane(obs_q[j].re, k) != 2 * j + 16 + 2 * k) ok = 1'b0;
            n_checks++;
            if (!ok) begin
                n_errors++;
                $display("FAIL ramp_sums: got lane0 first=%0d, expected 2n+16+2k (16)",
                         olane(obs_q[0].re, 0));
            end
            ok = 1'b1;
            for (int j = D; j < 2 * D; j++)
                for (int k = 0; k < L; k++)
                    if (olane(obs_q[j].re, k) != -16) ok = 1'b0;
            n_checks++;
            if (!ok) begin
                n_errors++;
                $display("FAIL ramp_drain: got lane0 first=%0d, expected -16",
                         olane(obs_q[D].re, 0));
            end
        end
        n_checks++;
        if (do_valid !== 1'b0 || err !== 1'b0) begin
            n_errors++;
            $display("FAIL ramp_end: do_valid=%b err=%b, expected 0 0", do_valid, err);
        end
    endtask

    task automatic test_back_to_back();
        clear_stim();
        push_idle(1);
        frames.push_back(1);
        for (int n = 0; n < 2 * D; n++) push_cycle(1'b1, const_vec(100), '0);
        frames.push_back(1 + 2 * D);
        for (int n = 0; n < 2 * D; n++) push_cycle(1'b1, const_vec(-50), '0);
        push_idle(2 * D + 2);
        finalize_valid();
        play();
        n_checks++;
        if (obs_q.size() !== exp_q.size()) begin
            n_errors++;
            $display("FAIL b2b_count: got %0d outputs, expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_errors++;
                $display("FAIL b2b_out[%0d]: got cyc=%0d re=%h im=%h, expected cyc=%0d re=%h im=%h",
                         i, obs_q[i].cyc, obs_q[i].re, obs_q[i].im,
                         exp_q[i].cyc, exp_q[i].re, exp_q[i].im);
            end
        end
        if (obs_q.size() >= 4 * D) begin
            n_checks++;
            if (olane(obs_q[D].re, 0) != 0 || olane(obs_q[2*D].re, 3) != -100) begin
                n_errors++;
                $display("FAIL b2b_values: got A-diff=%0d B-sum=%0d, expected 0 -100",
                         olane(obs_q[D].re, 0), olane(obs_q[2*D].re, 3));
            end
        end
    endtask

    task automatic test_extremes();
        clear_stim();
        push_idle(1);
        frames.push_back(1);
        for (int n = 0; n < D; n++) push_cycle(1'b1, const_vec(511), const_vec(-512));
        for (int n = 0; n < D; n++) push_cycle(1'b1, const_vec(-512), const_vec(511));
        push_idle(2 * D + 2);
        finalize_valid();
        play();
        n_checks++;
        if (obs_q.size() !== exp_q.size()) begin
            n_errors++;
            $display("FAIL ext_count: got %0d outputs, expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_errors++;
                $display("FAIL ext_out[%0d]: got cyc=%0d re=%h im=%h, expected cyc=%0d re=%h im=%h",
                         i, obs_q[i].cyc, obs_q[i].re, obs_q[i].im,
                         exp_q[i].cyc, exp_q[i].re, exp_q[i].im);
            end
        end
        if (obs_q.size() >= 2 * D) begin
            n_checks++;
            if (olane(obs_q[0].re, 7) != -1 || olane(obs_q[0].im, 7) != -1 ||
                olane(obs_q[D].re, 7) != 1023 || olane(obs_q[D].im, 7) != -1023) begin
                n_errors++;
                $display("FAIL ext_values: got sum=%0d/%0d diff=%0d/%0d, expected -1/-1 1023/-1023",
                         olane(obs_q[0].re, 7), olane(obs_q[0].im, 7),
                         olane(obs_q[D].re, 7), olane(obs_q[D].im, 7));
            end
        end
    endtask

    task automatic test_random();
        clear_stim();
        push_idle(1);
        push_rand_frame();
        push_rand_frame();
        push_idle(D);
        push_rand_frame();
        push_idle(D + 5);
        push_rand_frame();
        push_idle(2 * D + 2);
        finalize_valid();
        play();
        n_checks++;
        if (obs_q.size() !== exp_q.size()) begin
            n_errors++;
            $display("FAIL rand_count: got %0d outputs, expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_errors++;
                $display("FAIL rand_out[%0d]: got cyc=%0d re=%h im=%h, expected cyc=%0d re=%h im=%h",
                         i, obs_q[i].cyc, obs_q[i].re, obs_q[i].im,
                         exp_q[i].cyc, exp_q[i].re, exp_q[i].im);
            end
        end
        n_checks++;
        if (err !== 1'b0) begin
            n_errors++;
            $display("FAIL rand_err: err=%b, expected 0", err);
        end
    endtask

    task automatic test_protocol();
        // din_valid dropped inside FILL: frame still runs to completion.
        clear_stim();
        push_idle(1);
        push_rand_frame();
        push_idle(2 * D + 2);
        finalize_valid();
        s_v[frames[0] + 5] = 1'b0;
        play();
        n_checks++;
        if (obs_q.size() !== exp_q.size()) begin
            n_errors++;
            $display("FAIL proto_fill_count: got %0d outputs, expected %0d",
                     obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_errors++;
                $display("FAIL proto_fill_out[%0d]: got cyc=%0d re=%h, expected cyc=%0d re=%h",
                         i, obs_q[i].cyc, obs_q[i].re, exp_q[i].cyc, exp_q[i].re);
            end
        end
        n_checks++;
        if (err !== 1'b1) begin
            n_errors++;
            $display("FAIL proto_fill_err: err=%b, expected 1", err);
        end
        pulse_reset();
        n_checks++;
        if (err !== 1'b0) begin
            n_errors++;
            $display("FAIL proto_err_clear: err=%b, expected 0", err);
        end
        // din_valid raised mid-DRAIN: ignored, no new frame.
        clear_stim();
        push_idle(1);
        push_rand_frame();
        push_idle(2 * D + 2);
        finalize_valid();
        for (int j = 3; j < 6; j++) s_v[frames[0] + 2 * D + j] = 1'b1;
        play();
        n_checks++;
        if (obs_q.size() !== exp_q.size()) begin
            n_errors++;
            $display("FAIL proto_drain_count: got %0d outputs, expected %0d",
                     obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_errors++;
                $display("FAIL proto_drain_out[%0d]: got cyc=%0d re=%h, expected cyc=%0d re=%h",
                         i, obs_q[i].cyc, obs_q[i].re, exp_q[i].cyc, exp_q[i].re);
            end
        end
        n_checks++;
        if (err !== 1'b1 || do_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL proto_drain_err: err=%b do_valid=%b, expected 1 0", err, do_valid);
        end
    endtask

    task automatic test_reset_mid_bfly();
        clear_stim();
        push_idle(1);
        for (int n = 0; n < D + 5; n++) push_cycle(1'b1, rand_vec(), rand_vec());
        finalize_valid();
        s_v[3] = 1'b0;
        play();
        n_checks++;
        if (err !== 1'b1 || do_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL midb_pre: err=%b do_valid=%b, expected 1 1", err, do_valid);
        end
        #2;
        rstn = 1'b0;
        #1;
        n_checks++;
        if (do_valid !== 1'b0 || err !== 1'b0 || out_re !== '0 || out_im !== '0) begin
            n_errors++;
            $display("FAIL midb_async: do_valid=%b err=%b re=%h, expected 0 0 zero",
                     do_valid, err, out_re);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        clear_stim();
        push_idle(2);
        push_rand_frame();
        push_idle(2 * D + 2);
        finalize_valid();
        play();
        n_checks++;
        if (obs_q.size() !== exp_q.size()) begin
            n_errors++;
            $display("FAIL midb_count: got %0d outputs, expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_errors++;
                $display("FAIL midb_out[%0d]: got cyc=%0d re=%h, expected cyc=%0d re=%h",
                         i, obs_q[i].cyc, obs_q[i].re, exp_q[i].cyc, exp_q[i].re);
            end
        end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_back_to_back();
        test_extremes();
        test_random();
        test_protocol();
        test_reset_mid_bfly();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
